// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding control for the 5-stage pipeline.
// Define STALL_CNT_EN to add the stall_cycles / lu_events counters.
module hazard_fwd_unit #(
   parameter int AW           = 5,
   parameter int LOAD_USE_CYC = 1,
   parameter int CNT_W        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] D_Rs,
   input  logic [AW-1:0] D_Rt,
   input  logic [AW-1:0] E_Rs,
   input  logic [AW-1:0] E_Rt,
   input  logic [AW-1:0] E_Rw,
   input  logic          E_RegWr,
   input  logic          E_MemRd,
   input  logic [AW-1:0] M_Rw,
   input  logic [AW-1:0] M_Rt,
   input  logic          M_RegWr,
   input  logic          M_MemRd,
   input  logic          M_MemWr,
   input  logic [AW-1:0] W_Rw,
   input  logic          W_RegWr,
   input  logic          mem_ready,
   output logic [1:0]    fwd_A,
   output logic [1:0]    fwd_B,
   output logic          fwd_store,
   output logic          stall,
   output logic          flush_ex,
   output logic          mem_stall
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] lu_events
`endif
);

   if (LOAD_USE_CYC < 1 || LOAD_USE_CYC > 7 || CNT_W < 1) begin : g_bad_cfg
      $error("hazard_fwd_unit: illegal parameter set");
   end

   typedef enum logic {RUN, LU_STALL} state_t;

   localparam logic [2:0] CNT_INIT = 3'(LOAD_USE_CYC - 1);

   state_t     state;
   logic [2:0] cnt;
   logic       lu;
   logic       mw;
   logic       lu_start;
   logic       lu_active;

   // MEM result wins over WB; a load in MEM has no data yet
   function automatic logic [1:0] fwd_sel(
      input logic [AW-1:0] src,
      input logic [AW-1:0] m_rw,
      input logic          m_wr,
      input logic          m_ld,
      input logic [AW-1:0] w_rw,
      input logic          w_wr
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m_wr && !m_ld && m_rw != '0 && m_rw == src)
         sel = 2'b10;
      else if (w_wr && w_rw != '0 && w_rw == src)
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      lu = E_MemRd && E_RegWr && E_Rw != '0
         && (E_Rw == D_Rs || E_Rw == D_Rt);
      mw = (M_MemRd || M_MemWr) && !mem_ready;
      lu_start  = !rst && state == RUN && lu && !mw;
      lu_active = !rst && ((state == RUN && lu) || state == LU_STALL);
      mem_stall = !rst && mw;
      stall     = mem_stall || lu_active;
      flush_ex  = lu_active && !mw;
      fwd_A     = 2'b00;
      fwd_B     = 2'b00;
      fwd_store = 1'b0;
      if (!rst) begin
         fwd_A = fwd_sel(E_Rs, M_Rw, M_RegWr, M_MemRd, W_Rw, W_RegWr);
         fwd_B = fwd_sel(E_Rt, M_Rw, M_RegWr, M_MemRd, W_Rw, W_RegWr);
         fwd_store = M_MemWr && W_RegWr && W_Rw != '0 && W_Rw == M_Rt;
      end
   end

   // The RUN cycle that detects the hazard supplies the first bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         unique case (state)
            RUN: begin
               if (lu_start && LOAD_USE_CYC > 1) begin
                  state <= LU_STALL;
                  cnt   <= CNT_INIT;
               end
            end
            LU_STALL: begin
               if (!mw) begin
                  if (cnt == 3'd1) begin
                     state <= RUN;
                     cnt   <= 3'd0;
                  end else begin
                     cnt <= cnt - 3'd1;
                  end
               end
            end
            default: begin
               state <= RUN;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

`ifdef STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         lu_events    <= '0;
      end else begin
         if (stall)
            stall_cycles <= stall_cycles + 1'b1;
         if (lu_start)
            lu_events <= lu_events + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: LOAD_USE_CYC=1 and =3 instances share stimulus,
// checked every cycle against a bubble-budget model plus literal checks.
module tb_hazard_fwd_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] D_Rs, D_Rt, E_Rs, E_Rt, E_Rw, M_Rw, M_Rt, W_Rw;
   logic       E_RegWr, E_MemRd, M_RegWr, M_MemRd, M_MemWr;
   logic       W_RegWr, mem_ready;

   logic [1:0] fa [2];
   logic [1:0] fb [2];
   logic       fs [2];
   logic       st [2];
   logic       fl [2];
   logic       ms [2];
`ifdef STALL_CNT_EN
   logic [31:0] sc [2];
   logic [31:0] le [2];
   logic [31:0] m_sc [2];
   logic [31:0] m_le [2];
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int rem [2];
   int lcyc [2] = '{1, 3};

   always #5 clk = ~clk;

   hazard_fwd_unit #(.AW(5), .LOAD_USE_CYC(1), .CNT_W(32)) u1 (
      .clk(clk), .rst(rst),
      .D_Rs(D_Rs), .D_Rt(D_Rt), .E_Rs(E_Rs), .E_Rt(E_Rt),
      .E_Rw(E_Rw), .E_RegWr(E_RegWr), .E_MemRd(E_MemRd),
      .M_Rw(M_Rw), .M_Rt(M_Rt), .M_RegWr(M_RegWr),
      .M_MemRd(M_MemRd), .M_MemWr(M_MemWr),
      .W_Rw(W_Rw), .W_RegWr(W_RegWr), .mem_ready(mem_ready),
      .fwd_A(fa[0]), .fwd_B(fb[0]), .fwd_store(fs[0]),
      .stall(st[0]), .flush_ex(fl[0]), .mem_stall(ms[0])
`ifdef STALL_CNT_EN
      , .stall_cycles(sc[0]), .lu_events(le[0])
`endif
   );

   hazard_fwd_unit #(.AW(5), .LOAD_USE_CYC(3), .CNT_W(32)) u3 (
      .clk(clk), .rst(rst),
      .D_Rs(D_Rs), .D_Rt(D_Rt), .E_Rs(E_Rs), .E_Rt(E_Rt),
      .E_Rw(E_Rw), .E_RegWr(E_RegWr), .E_MemRd(E_MemRd),
      .M_Rw(M_Rw), .M_Rt(M_Rt), .M_RegWr(M_RegWr),
      .M_MemRd(M_MemRd), .M_MemWr(M_MemWr),
      .W_Rw(W_Rw), .W_RegWr(W_RegWr), .mem_ready(mem_ready),
      .fwd_A(fa[1]), .fwd_B(fb[1]), .fwd_store(fs[1]),
      .stall(st[1]), .flush_ex(fl[1]), .mem_stall(ms[1])
`ifdef STALL_CNT_EN
      , .stall_cycles(sc[1]), .lu_events(le[1])
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] r);
      if (rst) return 2'b00;
      if (M_RegWr && !M_MemRd && M_Rw != 0 && M_Rw == r) return 2'b10;
      if (W_RegWr && W_Rw != 0 && W_Rw == r) return 2'b01;
      return 2'b00;
   endfunction

   // Model: a hazard grants a budget of bubbles spent only on unfrozen cycles
   always @(negedge clk) begin
      logic mw, lu, e_st, e_fl, e_fs;
      mw = (M_MemRd || M_MemWr) && !mem_ready;
      lu = E_MemRd && E_RegWr && E_Rw != 0 && (E_Rw == D_Rs || E_Rw == D_Rt);
      e_fs = !rst && M_MemWr && W_RegWr && W_Rw != 0 && W_Rw == M_Rt;
      for (int i = 0; i < 2; i++) begin
         e_st = !rst && (mw || rem[i] > 0 || lu);
         e_fl = !rst && !mw && (rem[i] > 0 || lu);
         chk($sformatf("fwdA%0d", i), 32'(fa[i]), 32'(m_fwd(E_Rs)));
         chk($sformatf("fwdB%0d", i), 32'(fb[i]), 32'(m_fwd(E_Rt)));
         chk($sformatf("fwdst%0d", i), 32'(fs[i]), 32'(e_fs));
         chk($sformatf("stall%0d", i), 32'(st[i]), 32'(e_st));
         chk($sformatf("flush%0d", i), 32'(fl[i]), 32'(e_fl));
         chk($sformatf("mstall%0d", i), 32'(ms[i]), 32'(!rst && mw));
`ifdef STALL_CNT_EN
         if (!rst) begin
            chk($sformatf("scnt%0d", i), sc[i], m_sc[i]);
            chk($sformatf("lcnt%0d", i), le[i], m_le[i]);
         end
         if (rst) begin
            m_sc[i] = 0;
            m_le[i] = 0;
         end else begin
            m_sc[i] += 32'(e_st);
            m_le[i] += 32'(rem[i] == 0 && lu && !mw);
         end
`endif
         if (rst)
            rem[i] = 0;
         else if (rem[i] > 0) begin
            if (!mw) rem[i]--;
         end else if (lu && !mw)
            rem[i] = lcyc[i] - 1;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rst = 1'b0;
      {D_Rs, D_Rt, E_Rs, E_Rt, E_Rw, M_Rw, M_Rt, W_Rw} = '0;
      {E_RegWr, E_MemRd, M_RegWr, M_MemRd, M_MemWr, W_RegWr} = '0;
      mem_ready = 1'b1;
   endtask

   task automatic load_use();
      E_MemRd = 1'b1;
      E_RegWr = 1'b1;
      E_Rw    = 5'd4;
      D_Rt    = 5'd4;
   endtask

   initial begin
      int nfl;
`ifdef STALL_CNT_EN
      logic [31:0] sc0, le0;
`endif
      rem = '{0, 0};
`ifdef STALL_CNT_EN
      m_sc = '{0, 0};
      m_le = '{0, 0};
`endif
      clr();
      rst = 1'b1;
      E_Rs = 5'd3; M_Rw = 5'd3; M_RegWr = 1'b1;
      load_use();
      @(negedge clk);
      chk("rst_fwdA", 32'(fa[0]), 32'd0);
      chk("rst_stall", 32'(st[1]), 32'd0);
      nxt();
      nxt();
      clr();

      M_Rw = 5'd3; M_RegWr = 1'b1; W_Rw = 5'd3; W_RegWr = 1'b1;
      E_Rs = 5'd3;
      @(negedge clk);
      chk("lit_fwdA_mem", 32'(fa[0]), 32'd2);
      nxt();
      M_RegWr = 1'b0;
      @(negedge clk);
      chk("lit_fwdA_wb", 32'(fa[0]), 32'd1);
      nxt();
      M_RegWr = 1'b1; M_MemRd = 1'b1;
      @(negedge clk);
      chk("lit_fwdA_ld", 32'(fa[1]), 32'd1);

      nxt(); clr();
      M_Rw = 5'd0; M_RegWr = 1'b1; E_Rt = 5'd0; W_Rw = 5'd0; W_RegWr = 1'b1;
      @(negedge clk);
      chk("lit_fwdB_r0", 32'(fb[0]), 32'd0);
      nxt();
      M_MemWr = 1'b1; M_Rt = 5'd5; W_Rw = 5'd5; E_Rt = 5'd5;
      @(negedge clk);
      chk("lit_fwdst", 32'(fs[0]), 32'd1);
      chk("lit_fwdB_wb", 32'(fb[1]), 32'd1);

      nxt(); clr();
`ifdef STALL_CNT_EN
      sc0 = sc[1];
      le0 = le[1];
`endif
      load_use();
      @(negedge clk);
      chk("lit_lu1_st", 32'(st[0]), 32'd1);
      chk("lit_lu1_fl", 32'(fl[0]), 32'd1);
      chk("lit_lu3_fl_a", 32'(fl[1]), 32'd1);
      nxt(); clr();
      @(negedge clk);
      chk("lit_lu1_end", 32'(st[0]), 32'd0);
      chk("lit_lu3_fl_b", 32'(fl[1]), 32'd1);
      nxt();
      @(negedge clk);
      chk("lit_lu3_fl_c", 32'(fl[1]), 32'd1);
      nxt();
      @(negedge clk);
      chk("lit_lu3_end", 32'(st[1]), 32'd0);
`ifdef STALL_CNT_EN
      nxt();
      @(negedge clk);
      chk("lit_lu_events", le[1] - le0, 32'd1);
      chk("lit_stall_cycles", sc[1] - sc0, 32'd3);
`endif

      nxt(); clr();
      nfl = 0;
      load_use();
      @(negedge clk);
      nfl += int'(fl[1]);
      nxt(); clr();
      M_MemRd = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      chk("lit_mw_ms", 32'(ms[1]), 32'd1);
      chk("lit_mw_fl", 32'(fl[1]), 32'd0);
      nfl += int'(fl[1]);
      nxt();
      @(negedge clk);
      chk("lit_mw_ms2", 32'(ms[1]), 32'd1);
      nfl += int'(fl[1]);
      nxt(); clr();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         nfl += int'(fl[1]);
         nxt();
      end
      chk("lit_mw_total", 32'(nfl), 32'd3);

      clr();
      load_use();
      @(negedge clk);
      chk("lit_prerst_fl", 32'(fl[1]), 32'd1);
      nxt(); clr();
      rst = 1'b1;
      M_Rw = 5'd2; M_RegWr = 1'b1; E_Rs = 5'd2;
      @(negedge clk);
      chk("lit_rst_st", 32'(st[1]), 32'd0);
      chk("lit_rst_fl", 32'(fl[1]), 32'd0);
      chk("lit_rst_fa", 32'(fa[1]), 32'd0);
      nxt(); clr();
      @(negedge clk);
      chk("lit_postrst_st", 32'(st[1]), 32'd0);

      for (int k = 0; k < 200; k++) begin
         nxt();
         rst       = ($urandom_range(0, 24) == 0);
         D_Rs      = 5'($urandom_range(0, 3));
         D_Rt      = 5'($urandom_range(0, 3));
         E_Rs      = 5'($urandom_range(0, 3));
         E_Rt      = 5'($urandom_range(0, 3));
         E_Rw      = 5'($urandom_range(0, 3));
         M_Rw      = 5'($urandom_range(0, 3));
         M_Rt      = 5'($urandom_range(0, 3));
         W_Rw      = 5'($urandom_range(0, 3));
         E_RegWr   = 1'($urandom_range(0, 1));
         E_MemRd   = 1'($urandom_range(0, 1));
         M_RegWr   = 1'($urandom_range(0, 1));
         M_MemRd   = 1'($urandom_range(0, 1));
         M_MemWr   = 1'($urandom_range(0, 1));
         W_RegWr   = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 3) != 0);
      end
      nxt(); clr();
      repeat (8) nxt();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
